// File: rtl/golden_nonce_collector_pkg.sv
// Shared constants and types for the golden nonce collector.
// Holds the SHA-256 IV word, the derived match value and pipeline latency.
package golden_nonce_collector_pkg;

    // Final H = E + IV_H; a zero final word needs E == 0 - IV_H.
    localparam logic [31:0] SHA256_IV_H    = 32'h5be0cd19;
    localparam logic [31:0] GN_MATCH_VALUE = 32'h0 - SHA256_IV_H;

    localparam int GN_LATENCY = 136;
    localparam int GN_FIFO_AW = 2;

    // Two unrolled-by-LOOP passes of 64 rounds plus fixed I/O staging.
    function automatic int gn_default_latency(input int loop);
        return 2 * (64 / loop) + 8;
    endfunction

    typedef struct packed {
        logic        hit;
        logic [31:0] nonce;
    } gn_stage1_t;

endpackage

// File: rtl/golden_nonce_collector_fifo.sv
// gn_fifo: small synchronous FIFO with flush and registered head data.
// Ports: clk, i_reset, i_flush, i_push/i_wdata, i_pop, o_rdata, o_full, o_empty.
module gn_fifo #(
    parameter int AW = 2,
    parameter int W  = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

    logic [W-1:0]  r_mem [0:(1<<AW)-1];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_cnt;
    logic [W-1:0]  r_rdata;

    logic          w_pop;
    logic          w_push;
    logic [AW-1:0] w_rd_nxt;
    logic [AW:0]   w_cnt_nxt;
    logic [W-1:0]  w_head_nxt;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == DEPTH);
    assign o_rdata = r_rdata;

    assign w_pop     = i_pop && !o_empty;
    // A full FIFO still accepts a write when a pop frees a slot.
    assign w_push    = i_push && (!o_full || w_pop);
    assign w_rd_nxt  = w_pop ? r_rd + 1'b1 : r_rd;
    assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

    // The new head is the word being written when it lands in the head slot.
    assign w_head_nxt = (w_push && (w_rd_nxt == r_wr)) ? i_wdata
                                                        : r_mem[w_rd_nxt];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (i_reset || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            r_rd    <= w_rd_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= (w_cnt_nxt == '0) ? '0 : w_head_nxt;
        end
    end

endmodule

// File: rtl/golden_nonce_collector.sv
// Detects a zero final hash word, rewinds the nonce by the pipeline latency
// and queues golden nonces for the transmitter.
// Ports: clk, reset (sync, high), new_work, nonce_in, hash_word, gn_ready,
//        gn_valid/gn_data (FIFO head), gn_dropped (sat), gn_found (wrap).
module golden_nonce_collector
    import golden_nonce_collector_pkg::*;
#(
    parameter int          LATENCY     = GN_LATENCY,
    parameter logic [31:0] MATCH_VALUE = GN_MATCH_VALUE,
    parameter int          FIFO_AW     = GN_FIFO_AW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_work,
    input  logic [31:0] nonce_in,
    input  logic [31:0] hash_word,
    input  logic        gn_ready,
    output logic        gn_valid,
    output logic [31:0] gn_data,
    output logic [7:0]  gn_dropped,
    output logic [15:0] gn_found
);

    localparam int          WW        = $clog2(LATENCY + 1);
    localparam logic [WW-1:0] WARM_LOAD = WW'(LATENCY);
    localparam logic [31:0] REWIND    = 32'(LATENCY);

    logic [WW-1:0] r_warm;
    gn_stage1_t    r_s1;
    logic [7:0]    r_dropped;
    logic [15:0]   r_found;

    logic w_full;
    logic w_empty;
    logic w_push_req;
    logic w_pop;
    logic w_accept;

    // Warm-up gate and compare stage; the rewound nonce rides with the hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warm <= WARM_LOAD;
            r_s1   <= '0;
        end else if (new_work) begin
            r_warm <= WARM_LOAD;
            r_s1   <= '0;
        end else begin
            if (r_warm != '0)
                r_warm <= r_warm - 1'b1;
            r_s1.hit   <= (hash_word == MATCH_VALUE) && (r_warm == '0);
            r_s1.nonce <= nonce_in - REWIND;
        end
    end

    // A flush discards both the pending hit and any pop this cycle.
    assign w_push_req = r_s1.hit && !new_work;
    assign w_pop      = gn_valid && gn_ready && !new_work;
    assign w_accept   = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_found   <= '0;
            r_dropped <= '0;
        end else begin
            if (w_accept)
                r_found <= r_found + 1'b1;
            if (w_push_req && !w_accept && (r_dropped != 8'hff))
                r_dropped <= r_dropped + 1'b1;
        end
    end

    gn_fifo #(
        .AW (FIFO_AW),
        .W  (32)
    ) u_fifo (
        .clk     (clk),
        .i_reset (reset),
        .i_flush (new_work),
        .i_push  (w_accept),
        .i_wdata (r_s1.nonce),
        .i_pop   (w_pop),
        .o_rdata (gn_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign gn_valid   = !w_empty;
    assign gn_dropped = r_dropped;
    assign gn_found   = r_found;

endmodule

// File: tb/tb_golden_nonce_collector.sv
// Directed bench for golden_nonce_collector with a scoreboard queue.
// Expected nonces are queued at stimulus time and checked on each pop.
module tb_golden_nonce_collector;

    localparam int          LAT     = 136;
    localparam logic [31:0] MATCH   = 32'ha41f32e7;
    localparam logic [31:0] NOMATCH = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        new_work;
    logic [31:0] nonce_in;
    logic [31:0] hash_word;
    logic        gn_ready;
    logic        gn_valid;
    logic [31:0] gn_data;
    logic [7:0]  gn_dropped;
    logic [15:0] gn_found;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sbq[$];

    golden_nonce_collector #(
        .LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .new_work   (new_work),
        .nonce_in   (nonce_in),
        .hash_word  (hash_word),
        .gn_ready   (gn_ready),
        .gn_valid   (gn_valid),
        .gn_data    (gn_data),
        .gn_dropped (gn_dropped),
        .gn_found   (gn_found)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rewind(input logic [31:0] n);
        return n - 32'(LAT);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer runs before every edge, then steps one cycle.
    task automatic tick();
        logic [31:0] e;
        if (gn_valid && gn_ready && !reset && !new_work) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected", 32'(gn_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_pop", gn_data, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        new_work  = 1'b0;
        nonce_in  = 32'h0;
        hash_word = NOMATCH;
        gn_ready  = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(gn_valid), 32'd0);
        check("rst_data", gn_data, 32'd0);
        check("rst_drop", 32'(gn_dropped), 32'd0);
        check("rst_found", 32'(gn_found), 32'd0);

        // warm-up: matches ignored for LAT cycles
        reset     = 1'b0;
        hash_word = MATCH;
        nonce_in  = 32'h55;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check("warm_valid", 32'(gn_valid), 32'd0);
        end
        hash_word = NOMATCH;
        tick();
        tick();
        check("warm_valid_end", 32'(gn_valid), 32'd0);
        check("warm_found", 32'(gn_found), 32'd0);

        // single hit, two-cycle latency to gn_valid
        sbq.push_back(rewind(32'h0000_0100));
        hash_word = MATCH;
        nonce_in  = 32'h0000_0100;
        tick();
        hash_word = NOMATCH;
        check("lat1_valid", 32'(gn_valid), 32'd0);
        tick();
        check("lat2_valid", 32'(gn_valid), 32'd1);
        check("hit_data", gn_data, 32'h0000_0078);
        check("hit_found", 32'(gn_found), 32'd1);
        gn_ready = 1'b1;
        tick();
        gn_ready = 1'b0;
        check("pop_valid", 32'(gn_valid), 32'd0);
        check("pop_data", gn_data, 32'd0);

        // rewind past zero
        sbq.push_back(rewind(32'h0000_0010));
        hash_word = MATCH;
        nonce_in  = 32'h0000_0010;
        tick();
        hash_word = NOMATCH;
        tick();
        check("wrap_data", gn_data, 32'hffff_ff88);
        gn_ready = 1'b1;
        tick();
        gn_ready = 1'b0;
        check("wrap_found", 32'(gn_found), 32'd2);

        // overflow: 6 hits, 4 kept
        for (int i = 0; i < 6; i++) begin
            if (i < 4)
                sbq.push_back(rewind(32'h1000 + 32'(i)));
            hash_word = MATCH;
            nonce_in  = 32'h1000 + 32'(i);
            tick();
        end
        hash_word = NOMATCH;
        tick();
        tick();
        check("full_drop", 32'(gn_dropped), 32'd2);
        check("full_found", 32'(gn_found), 32'd6);
        check("full_head", gn_data, rewind(32'h1000));

        // full + hit + pop in the same cycle
        sbq.push_back(rewind(32'h2000));
        hash_word = MATCH;
        nonce_in  = 32'h2000;
        tick();
        hash_word = NOMATCH;
        gn_ready  = 1'b1;
        tick();
        gn_ready = 1'b0;
        check("fpp_drop", 32'(gn_dropped), 32'd2);
        check("fpp_found", 32'(gn_found), 32'd7);
        check("fpp_valid", 32'(gn_valid), 32'd1);
        gn_ready = 1'b1;
        repeat (4) tick();
        gn_ready = 1'b0;
        check("fpp_empty", 32'(gn_valid), 32'd0);
        check("fpp_data0", gn_data, 32'd0);

        // flush with 3 queued, then a fresh warm-up
        for (int i = 0; i < 3; i++) begin
            sbq.push_back(rewind(32'h3100 + 32'(i)));
            hash_word = MATCH;
            nonce_in  = 32'h3100 + 32'(i);
            tick();
        end
        hash_word = NOMATCH;
        tick();
        tick();
        check("fl_valid_pre", 32'(gn_valid), 32'd1);
        check("fl_found_pre", 32'(gn_found), 32'd10);
        new_work = 1'b1;
        tick();
        new_work = 1'b0;
        sbq.delete();
        check("fl_valid", 32'(gn_valid), 32'd0);
        check("fl_data", gn_data, 32'd0);
        check("fl_found", 32'(gn_found), 32'd10);
        hash_word = MATCH;
        nonce_in  = 32'h3200;
        for (int i = 0; i < LAT; i++) begin
            tick();
            check("fl_warm", 32'(gn_valid), 32'd0);
        end
        sbq.push_back(rewind(32'h3300));
        nonce_in = 32'h3300;
        tick();
        hash_word = NOMATCH;
        check("fl_lat1", 32'(gn_valid), 32'd0);
        tick();
        check("fl_hit_valid", 32'(gn_valid), 32'd1);
        check("fl_hit_data", gn_data, rewind(32'h3300));
        gn_ready = 1'b1;
        tick();
        gn_ready = 1'b0;
        check("fl_found2", 32'(gn_found), 32'd11);

        // new_work coincident with a stage-1 hit
        hash_word = MATCH;
        nonce_in  = 32'h4000;
        tick();
        hash_word = NOMATCH;
        new_work  = 1'b1;
        tick();
        new_work = 1'b0;
        check("co_valid", 32'(gn_valid), 32'd0);
        check("co_found", 32'(gn_found), 32'd11);
        check("co_drop", 32'(gn_dropped), 32'd2);
        tick();
        check("co_valid2", 32'(gn_valid), 32'd0);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        repeat (LAT - 1) tick();

        // reset with 2 entries queued and gn_ready high
        sbq.push_back(rewind(32'h5000));
        sbq.push_back(rewind(32'h5001));
        hash_word = MATCH;
        nonce_in  = 32'h5000;
        tick();
        nonce_in = 32'h5001;
        tick();
        hash_word = NOMATCH;
        tick();
        tick();
        check("r6_valid_pre", 32'(gn_valid), 32'd1);
        check("r6_data_pre", gn_data, sbq[0]);
        check("r6_found_pre", 32'(gn_found), 32'd13);
        reset    = 1'b1;
        gn_ready = 1'b1;
        tick();
        sbq.delete();
        check("r6_valid", 32'(gn_valid), 32'd0);
        check("r6_data", gn_data, 32'd0);
        check("r6_drop", 32'(gn_dropped), 32'd0);
        check("r6_found", 32'(gn_found), 32'd0);
        reset    = 1'b0;
        gn_ready = 1'b0;
        tick();
        check("r6_valid2", 32'(gn_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
